uart_ctrl_tmr_regs: RTL and testbench
=====================================

# uart_ctrl_tmr_regs

Parametrised successor to the UART control-register core. It holds every configuration register of one UART channel in triple-modular-redundant form, with bitwise majority voting and continuous scrubbing, and counts detected upsets. It also adds a complete interrupt unit: set/clear mask, sticky write-1-to-clear status, and FIFO trigger-level detection. It sits between the host register bus and the UART TX/RX/baud-generator submodules.

## Interface
- `NUM_IRQ`, 16: interrupt vector width, minimum 4.
- `FIFO_LVL_W`, 8: width of FIFO level and trigger fields.
- `CNT_W`, 8: width of the upset counter.
- `DEFAULT_PERIOD`, 16'd20: reset value of the baud divider.
- `DEFAULT_UP`, 4'd10: reset value of `bit_comp[7:4]`.
- `DEFAULT_DOWN`, 4'd5: reset value of `bit_comp[3:0]`.
- `DEFAULT_RX_TRIG`, 1: reset RX trigger level.
- `DEFAULT_TX_TRIG`, 0: reset TX trigger level.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en_i`  in  1  register write strobe, one cycle per write.
- `wr_addr_i`  in  3  address: 0 MODE, 1 BAUD, 2 BITCOMP, 3 IER, 4 IDR, 5 ISR, 6 RXTRIG, 7 TXTRIG.
- `wr_data_i`  in  16  write data.
- `irq_event_i`  in  NUM_IRQ-3  external single-cycle event pulses; bit k maps to status bit k+2.
- `rx_level_i`, `tx_level_i`  in  FIFO_LVL_W  current FIFO fill levels.
- `mode_o`  out  8  voted MODE register.
- `baud_div_o`  out  16  voted BAUD register.
- `bit_comp_o`  out  8  voted BITCOMP register.
- `acq_num_per_bit_o`  out  5  `bit_comp_o[7:4] + bit_comp_o[3:0]`, range 0..30.
- `parity_en_o`, `big_end_o`, `parity_odd_o`  out  1 each  `mode_o[6]`, `mode_o[7]`, `mode_o[5]`.
- `uart_mode_o`  out  4  `mode_o[3:0]`, one-hot: 0001 normal, 0010 echo, 0100 local loop, 1000 remote loop.
- `irq_mask_o`  out  NUM_IRQ  interrupt enables, 1 = enabled.
- `irq_state_o`  out  NUM_IRQ  sticky interrupt status.
- `irq_o`  out  1  registered OR of `irq_state & irq_mask`.
- `seu_count_o`  out  CNT_W  saturating count of scrubbed upsets.

## Operation
- MODE, BAUD, BITCOMP, RXTRIG and TXTRIG each have three copies. The output value is the bitwise majority of the three.
- A write to one of these registers loads all three copies with the write data, truncated to the register width.
- A MODE write whose bits [3:0] are not one-hot stores 0001 in those bits. Bits [7:4] are stored as written.
- Scrubbing: in any cycle where a TMR register is not being written and its copies disagree, all three copies load the voted value.
- `seu_count_o` increments by 1 per cycle in which any register scrubs, and saturates at all-ones. It clears only on reset.
- IER write: `mask |= wr_data`. IDR write: `mask &= ~wr_data`. Only the low NUM_IRQ bits are used.
- Status bit sources:
  - Bit 0: rising edge of `rx_level_i >= rxtrig`.
  - Bit 1: rising edge of `tx_level_i <= txtrig`.
  - Bits 2..NUM_IRQ-2: `irq_event_i`.
  - Bit NUM_IRQ-1: any scrub this cycle.
- Status bits are sticky. An ISR write clears each bit where `wr_data` is 1.
- If a set source and a clear hit the same bit in the same cycle, set wins.
- The trigger conditions are registered, reset to 0, and edge-detected. A condition that is already true when it is cleared does not re-set the bit.
- A write to an undefined register field has no effect. `wr_en_i` low means no register changes apart from scrubbing and status sets.

## Timing
- Reset values:
  - MODE 8'h41 (parity enabled, even, little-end, normal mode).
  - BAUD DEFAULT_PERIOD; BITCOMP {DEFAULT_UP, DEFAULT_DOWN}, so `acq_num_per_bit_o` = 15.
  - Trigger registers at their defaults.
  - Mask 0, status 0, `irq_o` 0, `seu_count_o` 0, condition registers 0.
- Config writes are sampled at edge N. The voted outputs and derived fields show the new value after edge N (combinational vote from the copies).
- An event at edge N sets its status bit after edge N. `irq_o` rises after edge N+1.
- Trigger path: the level crosses in cycle N, the condition register is set at edge N, and the status bit sets at edge N+1.
- With TXTRIG = 0 and an empty TX FIFO, status bit 1 sets one cycle after reset is released. This is intended.
- A scrub completes in one edge. Its status bit and the counter increment update at that same edge.
- Reset asserted mid-operation forces all reset values immediately (asynchronously).

## Structure
- Package `uart_ctrl_pkg` holds:
  - The address constants ADDR_MODE..ADDR_TXTRIG.
  - The mode one-hot encodings NORMAL/ECHO/LOCAL_LOOP/REMOTE_LOOP.
  - The interrupt bit indices IRQ_RX_TRIG = 0 and IRQ_TX_TRIG = 1, with IRQ_SEU at NUM_IRQ-1.
  - The MODE reset constant.
- Sub-module `tmr_reg #(W, RST_VAL)` has ports `clk`, `rst`, `we`, `d`, `q` (voted) and `mismatch`. It is instantiated five times. The top level ORs the `mismatch` outputs.

## Test plan
- Reset release: `baud_div_o` = 20, `bit_comp_o` = 8'hA5, `acq_num_per_bit_o` = 15, `uart_mode_o` = 0001, `irq_o` = 0, and status bit 1 sets after one cycle with `tx_level_i` = 0.
- Write BITCOMP 8'hFF: `acq_num_per_bit_o` = 30. Write MODE 8'hE3: mode stored as 8'hE1, `parity_odd_o` = 1, `big_end_o` = 1.
- Force one copy of BAUD to 16'h1234 while the others hold 16'h0014: `baud_div_o` stays 16'h0014, the copy is restored next edge, `seu_count_o` = 1, status bit 15 sets.
- IER 16'h0004, then pulse `irq_event_i[0]`: status bit 2 sets and `irq_o` = 1 one cycle later. ISR write 16'h0004 clears the bit, and `irq_o` falls on the following edge.
- ISR clear of bit 2 in the same cycle as an `irq_event_i[0]` pulse: the bit stays 1.
- RXTRIG = 4, `rx_level_i` steps 3 → 4 → 5: status bit 0 sets exactly once. After clearing it while the level is still 5, it stays 0. Forcing 255 upsets with `CNT_W` = 8 holds `seu_count_o` at 255.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared constants and helpers for the TMR UART control-register block:
// register addresses, mode encodings, interrupt bit positions.
package uart_ctrl_pkg;

    localparam logic [2:0] ADDR_MODE    = 3'd0;
    localparam logic [2:0] ADDR_BAUD    = 3'd1;
    localparam logic [2:0] ADDR_BITCOMP = 3'd2;
    localparam logic [2:0] ADDR_IER     = 3'd3;
    localparam logic [2:0] ADDR_IDR     = 3'd4;
    localparam logic [2:0] ADDR_ISR     = 3'd5;
    localparam logic [2:0] ADDR_RXTRIG  = 3'd6;
    localparam logic [2:0] ADDR_TXTRIG  = 3'd7;

    localparam logic [3:0] MODE_NORMAL      = 4'b0001;
    localparam logic [3:0] MODE_ECHO        = 4'b0010;
    localparam logic [3:0] MODE_LOCAL_LOOP  = 4'b0100;
    localparam logic [3:0] MODE_REMOTE_LOOP = 4'b1000;

    localparam logic [7:0] MODE_RST = 8'h41;

    localparam int IRQ_RX_TRIG = 0;
    localparam int IRQ_TX_TRIG = 1;

    // The upset status bit always occupies the top of the interrupt vector.
    function automatic int irq_seu_idx(input int num_irq);
        return num_irq - 1;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v == MODE_NORMAL) || (v == MODE_ECHO) ||
               (v == MODE_LOCAL_LOOP) || (v == MODE_REMOTE_LOOP);
    endfunction

endpackage

// File: rtl/uart_ctrl_tmr_regs_tmr_reg.sv
// Triple-redundant register: bitwise majority output, self-scrubbing when
// the copies disagree and no write is pending.
module tmr_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         mismatch
);

    logic [W-1:0] r_c0;
    logic [W-1:0] r_c1;
    logic [W-1:0] r_c2;
    logic         w_diff;

    assign q        = (r_c0 & r_c1) | (r_c0 & r_c2) | (r_c1 & r_c2);
    assign w_diff   = (r_c0 != r_c1) || (r_c0 != r_c2);
    assign mismatch = w_diff & ~we;

    // Copy storage: writes load all copies, otherwise disagreement re-loads the vote.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c0 <= RST_VAL;
            r_c1 <= RST_VAL;
            r_c2 <= RST_VAL;
        end else if (we) begin
            r_c0 <= d;
            r_c1 <= d;
            r_c2 <= d;
        end else if (w_diff) begin
            r_c0 <= q;
            r_c1 <= q;
            r_c2 <= q;
        end
    end

endmodule

// File: rtl/uart_ctrl_tmr_regs.sv
// UART channel configuration registers in TMR form with scrubbing, an upset
// counter and an interrupt unit (mask, sticky status, FIFO triggers).
module uart_ctrl_tmr_regs
    import uart_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ         = 16,
    parameter int          FIFO_LVL_W      = 8,
    parameter int          CNT_W           = 8,
    parameter logic [15:0] DEFAULT_PERIOD  = 16'd20,
    parameter logic [3:0]  DEFAULT_UP      = 4'd10,
    parameter logic [3:0]  DEFAULT_DOWN    = 4'd5,
    parameter int          DEFAULT_RX_TRIG = 1,
    parameter int          DEFAULT_TX_TRIG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [2:0]            wr_addr_i,
    input  logic [15:0]           wr_data_i,
    input  logic [NUM_IRQ-4:0]    irq_event_i,
    input  logic [FIFO_LVL_W-1:0] rx_level_i,
    input  logic [FIFO_LVL_W-1:0] tx_level_i,
    output logic [7:0]            mode_o,
    output logic [15:0]           baud_div_o,
    output logic [7:0]            bit_comp_o,
    output logic [4:0]            acq_num_per_bit_o,
    output logic                  parity_en_o,
    output logic                  big_end_o,
    output logic                  parity_odd_o,
    output logic [3:0]            uart_mode_o,
    output logic [NUM_IRQ-1:0]    irq_mask_o,
    output logic [NUM_IRQ-1:0]    irq_state_o,
    output logic                  irq_o,
    output logic [CNT_W-1:0]      seu_count_o
);

    // NUM_IRQ and FIFO_LVL_W are assumed not to exceed the 16-bit write bus.
    localparam int IRQ_SEU = irq_seu_idx(NUM_IRQ);

    logic                  w_we_mode, w_we_baud, w_we_bc, w_we_rxt, w_we_txt;
    logic                  w_we_ier, w_we_idr, w_we_isr;
    logic [7:0]            w_mode_d;
    logic [FIFO_LVL_W-1:0] w_rxtrig, w_txtrig;
    logic [4:0]            w_mm;
    logic                  w_scrub;
    logic [NUM_IRQ-1:0]    w_set, w_clr, w_wdata_irq;

    logic                  r_rx_cond, r_rx_cond_q, r_tx_cond, r_tx_cond_q;
    logic [NUM_IRQ-1:0]    r_mask, r_state;
    logic                  r_irq;
    logic [CNT_W-1:0]      r_seu;

    // Address decode of the write strobe.
    always_comb begin
        {w_we_mode, w_we_baud, w_we_bc, w_we_ier} = 4'b0000;
        {w_we_idr, w_we_isr, w_we_rxt, w_we_txt}  = 4'b0000;
        if (wr_en_i) begin
            case (wr_addr_i)
                ADDR_MODE:    w_we_mode = 1'b1;
                ADDR_BAUD:    w_we_baud = 1'b1;
                ADDR_BITCOMP: w_we_bc   = 1'b1;
                ADDR_IER:     w_we_ier  = 1'b1;
                ADDR_IDR:     w_we_idr  = 1'b1;
                ADDR_ISR:     w_we_isr  = 1'b1;
                ADDR_RXTRIG:  w_we_rxt  = 1'b1;
                ADDR_TXTRIG:  w_we_txt  = 1'b1;
                default:      w_we_mode = 1'b0;
            endcase
        end else begin
            w_we_mode = 1'b0;
        end
    end

    // An invalid operating mode falls back to normal; the flag bits are kept.
    always_comb begin
        w_mode_d = {wr_data_i[7:4], MODE_NORMAL};
        if (is_onehot4(wr_data_i[3:0])) begin
            w_mode_d[3:0] = wr_data_i[3:0];
        end else begin
            w_mode_d[3:0] = MODE_NORMAL;
        end
    end

    tmr_reg #(.W(8), .RST_VAL(MODE_RST)) u_mode (
        .clk(clk), .rst(rst), .we(w_we_mode), .d(w_mode_d), .q(mode_o), .mismatch(w_mm[0]));
    tmr_reg #(.W(16), .RST_VAL(DEFAULT_PERIOD)) u_baud (
        .clk(clk), .rst(rst), .we(w_we_baud), .d(wr_data_i), .q(baud_div_o), .mismatch(w_mm[1]));
    tmr_reg #(.W(8), .RST_VAL({DEFAULT_UP, DEFAULT_DOWN})) u_bitcomp (
        .clk(clk), .rst(rst), .we(w_we_bc), .d(wr_data_i[7:0]), .q(bit_comp_o), .mismatch(w_mm[2]));
    tmr_reg #(.W(FIFO_LVL_W), .RST_VAL(FIFO_LVL_W'(DEFAULT_RX_TRIG))) u_rxtrig (
        .clk(clk), .rst(rst), .we(w_we_rxt), .d(wr_data_i[FIFO_LVL_W-1:0]), .q(w_rxtrig), .mismatch(w_mm[3]));
    tmr_reg #(.W(FIFO_LVL_W), .RST_VAL(FIFO_LVL_W'(DEFAULT_TX_TRIG))) u_txtrig (
        .clk(clk), .rst(rst), .we(w_we_txt), .d(wr_data_i[FIFO_LVL_W-1:0]), .q(w_txtrig), .mismatch(w_mm[4]));

    assign w_scrub           = |w_mm;
    assign w_wdata_irq       = wr_data_i[NUM_IRQ-1:0];
    assign acq_num_per_bit_o = {1'b0, bit_comp_o[7:4]} + {1'b0, bit_comp_o[3:0]};
    assign parity_en_o       = mode_o[6];
    assign big_end_o         = mode_o[7];
    assign parity_odd_o      = mode_o[5];
    assign uart_mode_o       = mode_o[3:0];

    // Status set/clear vectors; set sources are edge pulses.
    always_comb begin
        w_set                 = '0;
        w_set[IRQ_RX_TRIG]    = r_rx_cond & ~r_rx_cond_q;
        w_set[IRQ_TX_TRIG]    = r_tx_cond & ~r_tx_cond_q;
        w_set[IRQ_SEU-1:2]    = irq_event_i;
        w_set[IRQ_SEU]        = w_scrub;
        if (w_we_isr) begin
            w_clr = w_wdata_irq;
        end else begin
            w_clr = '0;
        end
    end

    // Trigger conditions and their delayed copies for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_cond   <= 1'b0;
            r_rx_cond_q <= 1'b0;
            r_tx_cond   <= 1'b0;
            r_tx_cond_q <= 1'b0;
        end else begin
            r_rx_cond   <= (rx_level_i >= w_rxtrig);
            r_rx_cond_q <= r_rx_cond;
            r_tx_cond   <= (tx_level_i <= w_txtrig);
            r_tx_cond_q <= r_tx_cond;
        end
    end

    // Mask, sticky status (set beats clear), interrupt line and upset counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask  <= '0;
            r_state <= '0;
            r_irq   <= 1'b0;
            r_seu   <= '0;
        end else begin
            if (w_we_ier) begin
                r_mask <= r_mask | w_wdata_irq;
            end else if (w_we_idr) begin
                r_mask <= r_mask & ~w_wdata_irq;
            end
            r_state <= (r_state & ~w_clr) | w_set;
            r_irq   <= |(r_state & r_mask);
            if (w_scrub && (r_seu != {CNT_W{1'b1}})) begin
                r_seu <= r_seu + CNT_W'(1);
            end
        end
    end

    assign irq_mask_o  = r_mask;
    assign irq_state_o = r_state;
    assign irq_o       = r_irq;
    assign seu_count_o = r_seu;

endmodule

// File: tb/tb_uart_ctrl_tmr_regs.sv
// Directed self-checking bench for uart_ctrl_tmr_regs.
module tb_uart_ctrl_tmr_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en_i = 1'b0;
    logic [2:0]  wr_addr_i = 3'd0;
    logic [15:0] wr_data_i = 16'h0000;
    logic [12:0] irq_event_i = 13'h0000;
    logic [7:0]  rx_level_i = 8'd0;
    logic [7:0]  tx_level_i = 8'd0;
    logic [7:0]  mode_o;
    logic [15:0] baud_div_o;
    logic [7:0]  bit_comp_o;
    logic [4:0]  acq_num_per_bit_o;
    logic        parity_en_o, big_end_o, parity_odd_o;
    logic [3:0]  uart_mode_o;
    logic [15:0] irq_mask_o, irq_state_o;
    logic        irq_o;
    logic [7:0]  seu_count_o;

    int n_pass  = 0;
    int n_total = 0;

    uart_ctrl_tmr_regs u_dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .irq_event_i(irq_event_i), .rx_level_i(rx_level_i), .tx_level_i(tx_level_i),
        .mode_o(mode_o), .baud_div_o(baud_div_o), .bit_comp_o(bit_comp_o),
        .acq_num_per_bit_o(acq_num_per_bit_o), .parity_en_o(parity_en_o), .big_end_o(big_end_o),
        .parity_odd_o(parity_odd_o), .uart_mode_o(uart_mode_o), .irq_mask_o(irq_mask_o),
        .irq_state_o(irq_state_o), .irq_o(irq_o), .seu_count_o(seu_count_o));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick();
        wr_en_i = 1'b0; wr_data_i = 16'h0000;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_total++; if (baud_div_o !== 16'd20) $display("FAIL rst_baud got %h exp %h", baud_div_o, 16'd20); else n_pass++;
        n_total++; if (bit_comp_o !== 8'hA5) $display("FAIL rst_bitcomp got %h exp a5", bit_comp_o); else n_pass++;
        n_total++; if (acq_num_per_bit_o !== 5'd15) $display("FAIL rst_acq got %0d exp 15", acq_num_per_bit_o); else n_pass++;
        n_total++; if (mode_o !== 8'h41) $display("FAIL rst_mode got %h exp 41", mode_o); else n_pass++;
        n_total++; if (uart_mode_o !== 4'b0001) $display("FAIL rst_umode got %b exp 0001", uart_mode_o); else n_pass++;
        n_total++; if (irq_o !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq_o); else n_pass++;
        n_total++; if (seu_count_o !== 8'd0) $display("FAIL rst_seu got %0d exp 0", seu_count_o); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (irq_state_o !== 16'h0000) $display("FAIL rst_state_e1 got %h exp 0000", irq_state_o); else n_pass++;
        tick();
        n_total++; if (irq_state_o !== 16'h0002) $display("FAIL rst_txtrig got %h exp 0002", irq_state_o); else n_pass++;
    endtask

    task automatic test_config();
        wr(3'd2, 16'h00FF);
        n_total++; if (acq_num_per_bit_o !== 5'd30) $display("FAIL acq_max got %0d exp 30", acq_num_per_bit_o); else n_pass++;
        wr(3'd0, 16'h00E3);
        n_total++; if (mode_o !== 8'hE1) $display("FAIL mode_fix got %h exp e1", mode_o); else n_pass++;
        n_total++; if ({big_end_o, parity_en_o, parity_odd_o} !== 3'b111) $display("FAIL mode_flags got %b exp 111", {big_end_o, parity_en_o, parity_odd_o}); else n_pass++;
        wr(3'd0, 16'h0004);
        n_total++; if ({parity_en_o, uart_mode_o} !== 5'b0_0100) $display("FAIL mode_loop got %b exp 00100", {parity_en_o, uart_mode_o}); else n_pass++;
        wr_en_i = 1'b0; wr_addr_i = 3'd1; wr_data_i = 16'hFFFF;
        tick();
        wr_data_i = 16'h0000;
        n_total++; if (baud_div_o !== 16'd20) $display("FAIL no_wr_en got %h exp 0014", baud_div_o); else n_pass++;
    endtask

    task automatic test_scrub();
        force u_dut.u_baud.r_c0 = 16'h1234;
        #1 release u_dut.u_baud.r_c0;
        n_total++; if (baud_div_o !== 16'h0014) $display("FAIL scrub_vote got %h exp 0014", baud_div_o); else n_pass++;
        tick();
        n_total++; if (u_dut.u_baud.r_c0 !== 16'h0014) $display("FAIL scrub_fix got %h exp 0014", u_dut.u_baud.r_c0); else n_pass++;
        n_total++; if (seu_count_o !== 8'd1) $display("FAIL scrub_cnt got %0d exp 1", seu_count_o); else n_pass++;
        n_total++; if (irq_state_o[15] !== 1'b1) $display("FAIL scrub_irq got %b exp 1", irq_state_o[15]); else n_pass++;
        tick();
        n_total++; if (seu_count_o !== 8'd1) $display("FAIL scrub_once got %0d exp 1", seu_count_o); else n_pass++;
    endtask

    task automatic test_irq();
        wr(3'd5, 16'hFFFF);
        wr(3'd3, 16'h0004);
        n_total++; if (irq_mask_o !== 16'h0004) $display("FAIL ier got %h exp 0004", irq_mask_o); else n_pass++;
        irq_event_i = 13'h0001;
        tick();
        irq_event_i = 13'h0000;
        n_total++; if ({irq_state_o[2], irq_o} !== 2'b10) $display("FAIL evt_set got %b exp 10", {irq_state_o[2], irq_o}); else n_pass++;
        tick();
        n_total++; if (irq_o !== 1'b1) $display("FAIL irq_rise got %b exp 1", irq_o); else n_pass++;
        wr(3'd5, 16'h0004);
        n_total++; if ({irq_state_o[2], irq_o} !== 2'b01) $display("FAIL isr_clr got %b exp 01", {irq_state_o[2], irq_o}); else n_pass++;
        tick();
        n_total++; if (irq_o !== 1'b0) $display("FAIL irq_fall got %b exp 0", irq_o); else n_pass++;
        wr(3'd3, 16'h0010);
        wr(3'd4, 16'h0004);
        n_total++; if (irq_mask_o !== 16'h0010) $display("FAIL idr got %h exp 0010", irq_mask_o); else n_pass++;
    endtask

    task automatic test_set_wins();
        irq_event_i = 13'h0001;
        wr(3'd5, 16'h0004);
        irq_event_i = 13'h0000;
        n_total++; if (irq_state_o[2] !== 1'b1) $display("FAIL set_wins got %b exp 1", irq_state_o[2]); else n_pass++;
        wr(3'd5, 16'h0004);
        n_total++; if (irq_state_o[2] !== 1'b0) $display("FAIL set_wins_clr got %b exp 0", irq_state_o[2]); else n_pass++;
    endtask

    task automatic test_rx_trig();
        wr(3'd6, 16'h0004);
        rx_level_i = 8'd3; tick();
        rx_level_i = 8'd4; tick();
        n_total++; if (irq_state_o[0] !== 1'b0) $display("FAIL rxt_early got %b exp 0", irq_state_o[0]); else n_pass++;
        rx_level_i = 8'd5; tick();
        n_total++; if (irq_state_o[0] !== 1'b1) $display("FAIL rxt_set got %b exp 1", irq_state_o[0]); else n_pass++;
        wr(3'd5, 16'h0001);
        tick(); tick();
        n_total++; if (irq_state_o[0] !== 1'b0) $display("FAIL rxt_noreset got %b exp 0", irq_state_o[0]); else n_pass++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            force u_dut.u_baud.r_c0 = 16'h1234;
            #1 release u_dut.u_baud.r_c0;
            tick();
        end
        n_total++; if (seu_count_o !== 8'd255) $display("FAIL seu_sat got %0d exp 255", seu_count_o); else n_pass++;
        n_total++; if (baud_div_o !== 16'h0014) $display("FAIL seu_baud got %h exp 0014", baud_div_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        wr(3'd1, 16'h0123);
        #2 rst = 1'b1;
        #1;
        n_total++; if (baud_div_o !== 16'd20) $display("FAIL arst_baud got %h exp 0014", baud_div_o); else n_pass++;
        n_total++; if ({seu_count_o, irq_mask_o, irq_state_o} !== 40'd0) $display("FAIL arst_regs got %h exp 0", {seu_count_o, irq_mask_o, irq_state_o}); else n_pass++;
        n_total++; if (mode_o !== 8'h41) $display("FAIL arst_mode got %h exp 41", mode_o); else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_config();
        test_scrub();
        test_irq();
        test_set_wins();
        test_rx_trig();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
